// File: rtl/mul_accel_pkg.sv
// Shared types and helpers for the limb-serial multiplier family.
package mul_accel_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} mul_state_e;

endpackage

// File: rtl/limb_mul.sv
// Unsigned LIMB_W x LIMB_W multiplier with MUL_PIPE register stages; valid and
// {i,j} tag ride through the same stages so the product keeps its placement.
module limb_mul #(
    parameter int LIMB_W   = 66,
    parameter int MUL_PIPE = 1,
    parameter int TAG_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [LIMB_W-1:0]     a_i,
    input  logic [LIMB_W-1:0]     b_i,
    output logic                  vld_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [2*LIMB_W-1:0]   prod_o
);

    localparam int PW = 2 * LIMB_W;

    logic [PW-1:0] prod_p0;

    assign prod_p0 = PW'(a_i) * PW'(b_i);

    generate
        if (MUL_PIPE == 0) begin : g_comb
            assign vld_o  = vld_i;
            assign tag_o  = tag_i;
            assign prod_o = prod_p0;
        end else begin : g_pipe
            logic [MUL_PIPE-1:0] vld_p;
            logic [TAG_W-1:0]    tag_p  [MUL_PIPE];
            logic [PW-1:0]       prod_p [MUL_PIPE];

            // Only the valid chain is reset; stale data behind a cleared valid is never consumed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= vld_i;
                    for (int s = 1; s < MUL_PIPE; s++) begin
                        vld_p[s] <= vld_p[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                tag_p[0]  <= tag_i;
                prod_p[0] <= prod_p0;
                for (int s = 1; s < MUL_PIPE; s++) begin
                    tag_p[s]  <= tag_p[s-1];
                    prod_p[s] <= prod_p[s-1];
                end
            end

            assign vld_o  = vld_p[MUL_PIPE-1];
            assign tag_o  = tag_p[MUL_PIPE-1];
            assign prod_o = prod_p[MUL_PIPE-1];
        end
    endgenerate

endmodule

// File: rtl/limb_serial_mul.sv
// Wide unsigned multiplier P = A*B built from one shared limb multiplier,
// accumulating shifted partial products with valid/ready on both sides.
module limb_serial_mul
    import mul_accel_pkg::*;
#(
    parameter int A_W      = 131,
    parameter int B_W      = 128,
    parameter int LIMB_W   = 66,
    parameter int MUL_PIPE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   p,
    output logic                 busy
);

    localparam int NA    = ceil_div(A_W, LIMB_W);
    localparam int NB    = ceil_div(B_W, LIMB_W);
    localparam int NP    = NA * NB;
    localparam int P_W   = A_W + B_W;
    localparam int AP_W  = NA * LIMB_W;
    localparam int BP_W  = NB * LIMB_W;
    localparam int ACC_W = AP_W + BP_W;
    localparam int I_W   = (NA > 1) ? $clog2(NA) : 1;
    localparam int J_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int K_W   = (NP > 1) ? $clog2(NP) : 1;
    localparam int D_W   = (MUL_PIPE > 0) ? $clog2(MUL_PIPE + 1) : 1;
    localparam int TAG_W = I_W + J_W;

    mul_state_e state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [I_W-1:0] i_q, i_d;
    logic [J_W-1:0] j_q, j_d;
    logic [D_W-1:0] dcnt_q, dcnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [NA-1:0][LIMB_W-1:0] a_q;
    logic [NB-1:0][LIMB_W-1:0] b_q;

    logic accept;
    logic issue;

    logic                mul_vld;
    logic [TAG_W-1:0]    mul_tag;
    logic [2*LIMB_W-1:0] mul_prod;
    logic [I_W-1:0]      mul_ti;
    logic [J_W-1:0]      mul_tj;
    logic [ACC_W-1:0]    pp_sh;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        dcnt_d   = dcnt_q;
        issue    = 1'b0;
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
        case (state_q)
            IDLE: begin
                if (accept) state_d = MUL;
            end
            MUL: begin
                issue = 1'b1;
                if (k_q == K_W'(NP - 1)) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q + 1'b1;
                    if (j_q == J_W'(NB - 1)) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            // One cycle per pipe stage plus the accumulate edge keeps latency fixed.
            DRAIN: begin
                if (dcnt_q == D_W'(MUL_PIPE)) state_d = DONE;
                else dcnt_d = dcnt_q + 1'b1;
            end
            DONE: begin
                if (out_ready) state_d = accept ? MUL : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            k_d = '0;
            i_d = '0;
            j_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dcnt_q  <= dcnt_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= AP_W'(a);
            b_q <= BP_W'(b);
        end
    end

    limb_mul #(
        .LIMB_W  (LIMB_W),
        .MUL_PIPE(MUL_PIPE),
        .TAG_W   (TAG_W)
    ) u_limb_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (issue),
        .tag_i ({i_q, j_q}),
        .a_i   (a_q[i_q]),
        .b_i   (b_q[j_q]),
        .vld_o (mul_vld),
        .tag_o (mul_tag),
        .prod_o(mul_prod)
    );

    assign mul_ti = mul_tag[TAG_W-1:J_W];
    assign mul_tj = mul_tag[J_W-1:0];
    assign pp_sh  = ACC_W'(mul_prod) << ((32'(mul_ti) + 32'(mul_tj)) * LIMB_W);

    always_comb begin
        acc_d = acc_q;
        if (accept) acc_d = '0;
        else if (mul_vld) acc_d = acc_q + pp_sh;
    end

    assign p         = acc_q[P_W-1:0];
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DRAIN);

    generate
        if (ACC_W > P_W) begin : g_pad_chk
            always_ff @(posedge clk) begin
                if (rst_n) assert (acc_q[ACC_W-1:P_W] == '0);
            end
        end
    endgenerate

endmodule

// File: tb/tb_limb_serial_mul.sv
// Scoreboard bench: default 131x128 instance plus a 64x64 / 17-bit-limb / 2-stage instance.
module tb_limb_serial_mul;

    localparam int LAT1 = 6;
    localparam int LAT2 = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [130:0] a1;
    logic [127:0] b1;
    logic [258:0] p1;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [63:0]  a2, b2;
    logic [127:0] p2;

    limb_serial_mul dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .p(p1), .busy(busy1)
    );

    limb_serial_mul #(.A_W(64), .B_W(64), .LIMB_W(17), .MUL_PIPE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .p(p2), .busy(busy2)
    );

    typedef struct {
        logic [258:0] p;
        int           acc_cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic ov1_prev = 1'b0;
    logic ov2_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: latency on the rising edge of out_valid, data on every transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid1 && !ov1_prev && q1.size() != 0)
                chk("dut1 latency", 260'(cyc - q1[0].acc_cyc), 260'(LAT1));
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) chk("dut1 spurious out_valid", 260'(out_valid1), 260'(0));
                else begin
                    e1 = q1.pop_front();
                    chk("dut1 p", 260'(p1), 260'(e1.p));
                end
            end
        end
        ov1_prev = out_valid1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid2 && !ov2_prev && q2.size() != 0)
                chk("dut2 latency", 260'(cyc - q2[0].acc_cyc), 260'(LAT2));
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) chk("dut2 spurious out_valid", 260'(out_valid2), 260'(0));
                else begin
                    e2 = q2.pop_front();
                    chk("dut2 p", 260'(p2), 260'(e2.p));
                end
            end
        end
        ov2_prev = out_valid2;
    end

    task automatic go1(input logic [130:0] av, input logic [127:0] bv, input logic [258:0] ev,
                       input bit hold, input bit push);
        int g = 0;
        a1 = av; b1 = bv; in_valid1 = 1'b1;
        do begin @(negedge clk); g++; end while (!in_ready1 && g < 300);
        if (!in_ready1) begin
            chk("dut1 accept timeout", 260'(in_ready1), 260'(1));
            in_valid1 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) q1.push_back('{ev, cyc});
        if (!hold) begin
            in_valid1 = 1'b0;
            a1 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            b1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic go2(input logic [63:0] av, input logic [63:0] bv, input logic [127:0] ev,
                       input bit hold);
        int g = 0;
        a2 = av; b2 = bv; in_valid2 = 1'b1;
        do begin @(negedge clk); g++; end while (!in_ready2 && g < 300);
        if (!in_ready2) begin
            chk("dut2 accept timeout", 260'(in_ready2), 260'(1));
            in_valid2 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        q2.push_back('{259'(ev), cyc});
        if (!hold) begin
            in_valid2 = 1'b0;
            a2 = {$urandom(), $urandom()};
            b2 = {$urandom(), $urandom()};
        end
    endtask

    task automatic wait_idle1();
        int g = 0;
        while ((q1.size() != 0 || out_valid1) && g < 400) begin @(negedge clk); g++; end
        chk("dut1 drain", 260'(q1.size()), 260'(0));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle2();
        int g = 0;
        while ((q2.size() != 0 || out_valid2) && g < 400) begin @(negedge clk); g++; end
        chk("dut2 drain", 260'(q2.size()), 260'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [259:0] t;
        logic [258:0] snap;
        logic [130:0] ra;
        logic [127:0] rb;
        logic [63:0]  sa, sb;
        int g;

        rst_n = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 260'(in_ready1), 260'(1));
        chk("reset out_valid", 260'(out_valid1), 260'(0));
        chk("reset p", 260'(p1), 260'(0));
        chk("reset busy", 260'(busy1), 260'(0));
        chk("reset dut2 in_ready", 260'(in_ready2), 260'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones operands: (2^131-1)(2^128-1) = 2^259 - 2^131 - 2^128 + 1
        t = (260'd1 << 259) - (260'd1 << 131) - (260'd1 << 128) + 260'd1;
        go1('1, '1, t[258:0], 1'b0, 1'b1);
        chk("busy during op", 260'(busy1), 260'(1));
        wait_idle1();

        // Limb placement; junk in_valid while busy must be ignored.
        go1(131'd1, 128'd1 << 127, 259'd1 << 127, 1'b0, 1'b1);
        a1 = '1; b1 = '1; in_valid1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("in_ready while busy", 260'(in_ready1), 260'(0));
        end
        in_valid1 = 1'b0;
        wait_idle1();
        go1(131'd1 << 130, 128'd1 << 127, 259'd1 << 257, 1'b0, 1'b1);
        wait_idle1();
        go1(131'd0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_0001, 259'd0, 1'b0, 1'b1);
        wait_idle1();

        // Backpressure: 123456789 * 987654321 = 121932631112635269
        out_ready1 = 1'b0;
        go1(131'd123456789, 128'd987654321, 259'd121932631112635269, 1'b0, 1'b1);
        g = 0;
        do begin @(negedge clk); g++; end while (!out_valid1 && g < 50);
        chk("out_valid under backpressure", 260'(out_valid1), 260'(1));
        snap = p1;
        chk("p value held", 260'(snap), 260'(259'd121932631112635269));
        repeat (10) begin
            @(negedge clk);
            chk("hold p stable", 260'(p1), 260'(snap));
            chk("hold out_valid", 260'(out_valid1), 260'(1));
            chk("hold in_ready", 260'(in_ready1), 260'(0));
        end
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        chk("single transfer", 260'(out_valid1), 260'(0));
        chk("queue empty after release", 260'(q1.size()), 260'(0));

        // Three queued operations back to back.
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            go1(ra, rb, 259'(ra) * 259'(rb), (i < 2), 1'b1);
        end
        wait_idle1();

        // Reset mid-operation discards the result.
        go1('1, '1, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 260'(out_valid1), 260'(0));
        chk("midreset in_ready", 260'(in_ready1), 260'(1));
        chk("midreset busy", 260'(busy1), 260'(0));
        chk("midreset p", 260'(p1), 260'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT1 + 4) begin
            @(negedge clk);
            chk("no pulse after reset", 260'(out_valid1), 260'(0));
        end
        chk("in_ready after reset", 260'(in_ready1), 260'(1));
        @(posedge clk); #1;
        go1(131'd3, 128'd5, 259'd15, 1'b0, 1'b1);
        wait_idle1();

        // Second configuration: random vectors, then all-ones (2^128 - 2^65 + 1).
        for (int n = 0; n < 1000; n++) begin
            sa = {$urandom(), $urandom()};
            sb = {$urandom(), $urandom()};
            go2(sa, sb, 128'(sa) * 128'(sb), (n < 999));
        end
        wait_idle2();
        go2('1, '1, 128'd0 - (128'd1 << 65) + 128'd1, 1'b0);
        wait_idle2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
